fp_div: RTL

Sequential IEEE-754 double-precision divider, the companion of the team's mantissa-multiplier-based `fp_mult`. It accepts two 64-bit operands on a start strobe and computes `a / b` with a 54-iteration restoring division of the 53-bit significands, one quotient bit per cycle. It then normalises, computes sign and exponent, and presents a 64-bit result with a one-cycle `ready` pulse. Rounding is truncation and subnormals are flushed to zero, matching `fp_mult`'s numeric behaviour so the two can sit side by side behind the same VIO/probe harness.

---
 rtl/fp_div.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fp_div.sv
`default_nettype none
// ============================================================================
// Module   : fp_div
// Brief    : Sequential binary64 divider, 54-step restoring significand
//            division, truncating, subnormals flushed to zero.
// Revision : 1.0
// ============================================================================
module fp_div (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] out,
    output logic        ready,
    output logic        busy
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_DIV  = 2'd1;
    localparam logic [1:0] c_NORM = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]  r_state;
    logic [63:0] r_a;
    logic [63:0] r_b;
    logic [53:0] r_rem;
    logic [52:0] r_div;
    logic [53:0] r_quo;
    logic [5:0]  r_cnt;
    logic        r_sign;
    logic [12:0] r_exp;
    logic [51:0] r_mant;
    logic [63:0] r_out;
    logic        r_ready;
    logic        r_busy;

    logic [53:0] w_diff;
    logic        w_ge;
    logic        w_a_nan, w_a_inf, w_a_zero;
    logic        w_b_nan, w_b_inf, w_b_zero;
    logic [63:0] w_result;

    assign out   = r_out;
    assign ready = r_ready;
    assign busy  = r_busy;

    assign w_diff = r_rem - {1'b0, r_div};
    assign w_ge   = (r_rem >= {1'b0, r_div});

    assign w_a_zero = ~|r_a[62:52];
    assign w_b_zero = ~|r_b[62:52];
    assign w_a_nan  = (&r_a[62:52]) & (|r_a[51:0]);
    assign w_b_nan  = (&r_b[62:52]) & (|r_b[51:0]);
    assign w_a_inf  = (&r_a[62:52]) & ~(|r_a[51:0]);
    assign w_b_inf  = (&r_b[62:52]) & ~(|r_b[51:0]);

    // Special cases override the normal path; order sets their priority.
    always_comb begin
        w_result = {r_sign, r_exp[10:0], r_mant};
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf))
            w_result = 64'h7FF8_0000_0000_0000;
        else if (w_a_inf || w_b_zero)
            w_result = {r_sign, 11'h7FF, 52'd0};
        else if (w_a_zero || w_b_inf)
            w_result = {r_sign, 63'd0};
        else if ($signed(r_exp) >= 13'sd2047)
            w_result = {r_sign, 11'h7FF, 52'd0};
        else if ($signed(r_exp) <= 13'sd0)
            w_result = {r_sign, 63'd0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_a     <= 64'd0;
            r_b     <= 64'd0;
            r_rem   <= 54'd0;
            r_div   <= 53'd0;
            r_quo   <= 54'd0;
            r_cnt   <= 6'd0;
            r_sign  <= 1'b0;
            r_exp   <= 13'd0;
            r_mant  <= 52'd0;
            r_out   <= 64'd0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    // busy is only still high here during the ready cycle
                    if (r_busy) begin
                        r_busy <= 1'b0;
                    end else if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_rem   <= {2'b01, a[51:0]};
                        r_div   <= {1'b1, b[51:0]};
                        r_quo   <= 54'd0;
                        r_cnt   <= 6'd0;
                        r_busy  <= 1'b1;
                        r_state <= c_DIV;
                    end
                end
                c_DIV: begin
                    if (w_ge)
                        r_rem <= {w_diff[52:0], 1'b0};
                    else
                        r_rem <= {r_rem[52:0], 1'b0};
                    r_quo <= {r_quo[52:0], w_ge};
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd53)
                        r_state <= c_NORM;
                end
                c_NORM: begin
                    r_sign  <= r_a[63] ^ r_b[63];
                    r_exp   <= {2'b00, r_a[62:52]} - {2'b00, r_b[62:52]}
                               + (r_quo[53] ? 13'd1023 : 13'd1022);
                    r_mant  <= r_quo[53] ? r_quo[52:1] : r_quo[51:0];
                    r_state <= c_DONE;
                end
                default: begin
                    r_out   <= w_result;
                    r_ready <= 1'b1;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
